// File: rtl/div_iter_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative divider.
interface div_iter_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic             cancel;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, cancel, dividend, divisor,
        input  stall, done, quotient, remainder
    );

    modport slave (
        input  start, signed_op, cancel, dividend, divisor,
        output stall, done, quotient, remainder
    );
endinterface

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; produces LO (quotient) and HI (remainder).
// Signed operands are divided as magnitudes and the signs are restored on the final step.
module div_iter_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    div_iter_unit_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.cancel;

    // Operand magnitudes; the most negative value maps onto itself, which is correct unsigned.
    assign w_a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign w_b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? WIDTH'(-bus.dividend) : bus.dividend;
    assign w_b_mag = w_b_neg ? WIDTH'(-bus.divisor)  : bus.divisor;

    // One restoring shift-subtract step.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_rem_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_q_fix    = r_neg_q ? WIDTH'(-w_quo_next) : w_quo_next;
    assign w_r_fix    = r_neg_r ? WIDTH'(-w_rem_next) : w_rem_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.stall    = 1'b0;
        if (bus.cancel) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.stall    = 1'b1;
                        w_state_next = (bus.divisor == '0) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    bus.stall = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, and result write on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (bus.divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
            end
        end else if ((r_state == S_BUSY) && !bus.cancel) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
                r_quotient  <= w_q_fix;
                r_remainder <= w_r_fix;
            end
        end
    end

    assign bus.done      = (r_state == S_DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: a driver issues divides and queues expected results,
// a monitor compares them whenever done is presented.
module tb_div_iter_unit;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    div_iter_unit_if #(.WIDTH(WIDTH)) bus ();

    div_iter_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_r[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 q=0x%08h r=0x%08h",
                         bus.quotient, bus.remainder);
            end else begin
                logic [WIDTH-1:0] q;
                logic [WIDTH-1:0] r;
                q = exp_q.pop_front();
                r = exp_r.pop_front();
                check("quotient", bus.quotient, q);
                check("remainder", bus.remainder, r);
            end
        end
    end

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.cancel    = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
    endtask

    task automatic issue(input logic sg, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.start     = 1'b1;
        bus.signed_op = sg;
        bus.dividend  = a;
        bus.divisor   = b;
    endtask

    // Issue one divide, queue its result, count stall cycles up to and including done.
    task automatic run_op(input string name, input logic sg, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] q,
                          input logic [WIDTH-1:0] r, input int exp_stalls);
        int  stalls;
        bit  got;
        @(negedge clk);
        issue(sg, a, b);
        exp_q.push_back(q);
        exp_r.push_back(r);
        stalls = 0;
        got    = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                check({name, "_stall_in_done"}, WIDTH'(bus.stall), '0);
            end else if (bus.stall === 1'b1) begin
                stalls++;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        check({name, "_done_seen"}, WIDTH'(got), WIDTH'(1));
        check({name, "_stall_cycles"}, WIDTH'(stalls), WIDTH'(exp_stalls));
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_quotient", bus.quotient, '0);
        check("rst_remainder", bus.remainder, '0);
        check("rst_done", WIDTH'(bus.done), '0);
        check("rst_stall", WIDTH'(bus.stall), '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        run_op("divu_by0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        run_op("div_by0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);

        // Cancel at BUSY cycle 10: no done, previous result (div_by0) held.
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        #1;
        check("cancel_stall", WIDTH'(bus.stall), '0);
        @(negedge clk);
        bus.cancel = 1'b0;
        #1;
        check("cancel_idle_stall", WIDTH'(bus.stall), '0);
        repeat (40) @(negedge clk);
        check("cancel_hold_q", bus.quotient, 32'hFFFF_FFFF);
        check("cancel_hold_r", bus.remainder, 32'hFFFF_FFF9);

        // Start and cancel together: the start is dropped.
        issue(1'b0, 32'd100, 32'd7);
        bus.cancel = 1'b1;
        #1;
        check("start_cancel_stall", WIDTH'(bus.stall), '0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("start_cancel_idle", WIDTH'(bus.stall), '0);
        repeat (40) @(negedge clk);
        check("start_cancel_hold_q", bus.quotient, 32'hFFFF_FFFF);

        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Asynchronous reset mid-BUSY clears outputs immediately.
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_quotient", bus.quotient, '0);
        check("arst_remainder", bus.remainder, '0);
        check("arst_stall", WIDTH'(bus.stall), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_no_done_q", bus.quotient, '0);

        run_op("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 33);

        repeat (3) @(negedge clk);
        check("queue_drained", WIDTH'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
